// File: rtl/alu_result_adapter_pkg.sv
`default_nettype none
// ============================================================================
// alu_result_adapter_pkg : MDU opcode, writeback-select and MDU state encodings
// Revision: 1.0
// ============================================================================
package alu_result_adapter_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_HI  = 2'd2,
    WB_LO  = 2'd3
  } wb_sel_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
// mdu_iter_core : iterative shift-add multiplier / restoring divider
// Revision: 1.0
// ============================================================================
module mdu_iter_core
  import alu_result_adapter_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] res_hi,
  output logic [DATA_BITS-1:0] res_lo
);

  localparam int W  = DATA_BITS;
  localparam int CW = $clog2(DATA_BITS);

  mdu_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic         is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic         is_signed, a_neg, b_neg;
  logic [W-1:0] abs_a, abs_b;
  logic [W:0]   mul_sum, div_rem_in, div_diff;
  logic [W-1:0] step_hi, step_lo, quo_fix, rem_fix;
  logic [2*W-1:0] prod, prod_fix;

  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg     = is_signed && a[W-1];
  assign b_neg     = is_signed && b[W-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;

  // hi_q:lo_q is the 2W accumulator (mult) or remainder:dividend/quotient (div)
  assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
  assign div_rem_in = {hi_q, lo_q[W-1]};
  assign div_diff   = div_rem_in - {1'b0, opb_q};

  assign step_hi = is_div_q ? (div_diff[W] ? div_rem_in[W-1:0] : div_diff[W-1:0])
                            : mul_sum[W:1];
  assign step_lo = is_div_q ? {lo_q[W-2:0], ~div_diff[W]}
                            : {mul_sum[0], lo_q[W-1:1]};

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -step_lo : step_lo;
  assign rem_fix  = rneg_q ? -step_hi : step_hi;

  assign busy   = (state_q == S_RUN);
  assign done   = busy && (cnt_q == CW'(W-1));
  assign res_hi = is_div_q ? rem_fix : prod_fix[2*W-1:W];
  assign res_lo = is_div_q ? (dz_q ? {W{1'b1}} : quo_fix) : prod_fix[W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = abs_a;
          opb_d    = abs_b;
          is_div_d = (op == MDU_DIV) || (op == MDU_DIVU);
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = (b == '0);
        end
      end
      default: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (done) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_adapter.sv
`default_nettype none
// ============================================================================
// alu_result_adapter : HI/LO ownership, writeback mux and MDU stall generation
// Revision: 1.0
// ============================================================================
module alu_result_adapter
  import alu_result_adapter_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] AluA,
  input  logic [DATA_BITS-1:0] AluB,
  input  logic [DATA_BITS-1:0] AluResult,
  input  logic [DATA_BITS-1:0] MemData,
  input  logic                 MduStart,
  input  logic [2:0]           MduOp,
  input  logic [1:0]           WbSel,
  output logic [DATA_BITS-1:0] WbData,
  output logic                 MduBusy,
  output logic                 Stall,
  output logic [DATA_BITS-1:0] HiOut,
  output logic [DATA_BITS-1:0] LoOut
);

  logic [DATA_BITS-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_BITS-1:0] res_hi, res_lo;
  logic                 mdu_busy, mdu_done, accept, mdu_start;

  assign accept    = MduStart && !mdu_busy;
  assign mdu_start = accept && ((MduOp == MDU_MULT) || (MduOp == MDU_MULTU) ||
                                (MduOp == MDU_DIV)  || (MduOp == MDU_DIVU));

  mdu_iter_core #(
    .DATA_BITS (DATA_BITS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op     (MduOp),
    .a      (AluA),
    .b      (AluB),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // MTHI/MTLO can only be accepted while idle, so they never collide with done
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mdu_done) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (accept && (MduOp == MDU_MTHI)) begin
      hi_d = AluA;
    end else if (accept && (MduOp == MDU_MTLO)) begin
      lo_d = AluA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    case (WbSel)
      WB_MEM:  WbData = MemData;
      WB_HI:   WbData = hi_q;
      WB_LO:   WbData = lo_q;
      default: WbData = AluResult;
    endcase
  end

  assign MduBusy = mdu_busy;
  assign Stall   = mdu_busy && ((WbSel == WB_HI) || (WbSel == WB_LO) || MduStart);
  assign HiOut   = hi_q;
  assign LoOut   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_adapter.sv
`default_nettype none
// ============================================================================
// tb_alu_result_adapter : scoreboard bench with a 64-bit arithmetic reference
// Revision: 1.0
// ============================================================================
module tb_alu_result_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AluA, AluB, AluResult, MemData;
  logic        MduStart;
  logic [2:0]  MduOp;
  logic [1:0]  WbSel;
  logic [31:0] WbData, HiOut, LoOut;
  logic        MduBusy, Stall;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic        abort_pend = 1'b0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  always #5 clk = ~clk;

  alu_result_adapter #(.DATA_BITS(32)) dut (
    .clk(clk), .rst(rst), .AluA(AluA), .AluB(AluB), .AluResult(AluResult),
    .MemData(MemData), .MduStart(MduStart), .MduOp(MduOp), .WbSel(WbSel),
    .WbData(WbData), .MduBusy(MduBusy), .Stall(Stall), .HiOut(HiOut), .LoOut(LoOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, result packed as {HI, LO}
  function automatic logic [63:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (MduBusy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (MduBusy) chk("idle_timeout", 32'(MduBusy), 32'd0);
  endtask

  // Presents one request for a single edge; returns just after the accept edge
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    wait_idle();
    @(posedge clk); #1;
    MduStart = 1'b1; MduOp = op; AluA = a; AluB = b;
    if (op <= 3'd3) begin
      r = mdu_ref(op, a, b);
      exp_q.push_back(r);
      mdl_hi = r[63:32];
      mdl_lo = r[31:0];
    end else if (op == 3'd4) mdl_hi = a;
    else if (op == 3'd5) mdl_lo = a;
    chk("stall_on_idle_req", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    MduStart = 1'b0;
    AluA = $urandom;
    AluB = $urandom;
    if (op >= 3'd4) begin
      @(negedge clk);
      chk("move_busy", 32'(MduBusy), 32'd0);
      chk("move_hi", HiOut, mdl_hi);
      chk("move_lo", LoOut, mdl_lo);
    end
  endtask

  // Monitor: on each busy fall, check duration and pop the expected result
  initial begin
    logic prev;
    int   bc;
    logic [63:0] e;
    prev = 1'b0;
    bc = 0;
    forever begin
      @(negedge clk);
      if (MduBusy === 1'b1) bc++;
      else if (prev === 1'b1) begin
        if (abort_pend) abort_pend = 1'b0;
        else begin
          chk("busy_cycles", 32'(bc), 32'd32);
          if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("res_hi", HiOut, e[63:32]);
            chk("res_lo", LoOut, e[31:0]);
          end
        end
        bc = 0;
      end
      prev = MduBusy;
    end
  end

  initial begin
    logic [31:0] x;
    logic [1:0]  s;
    int          n;
    rst = 1'b1; MduStart = 1'b0; MduOp = '0; WbSel = '0;
    AluA = '0; AluB = '0; AluResult = '0; MemData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    chk("rst_busy", 32'(MduBusy), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);

    do_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
    chk("mult_neg3x5_hi", HiOut, 32'hFFFF_FFFF);
    chk("mult_neg3x5_lo", LoOut, 32'hFFFF_FFF1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd3, 32'd100, 32'd7);
    do_op(3'd3, 32'd7, 32'd0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd0);
    do_op(3'd2, 32'd7, 32'hFFFF_FFFE);

    // WbSel=LO requested mid-run stalls until the result lands
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(posedge clk);
    #1 WbSel = 2'd3;
    @(negedge clk);
    n = 0;
    while (MduBusy && n < 100) begin
      chk("stall_wb_lo", 32'(Stall), 32'd1);
      @(negedge clk);
      n++;
    end
    chk("stall_wb_lo_clear", 32'(Stall), 32'd0);
    chk("wb_new_lo", WbData, mdl_lo);
    WbSel = 2'd0;

    // Second request held across a busy op, accepted at the first idle edge
    do_op(3'd2, 32'hDEAD_BEEF, 32'd13);
    repeat (4) @(posedge clk);
    #1;
    MduStart = 1'b1; MduOp = 3'd3; AluA = 32'd1000; AluB = 32'd33;
    exp_q.push_back(mdu_ref(3'd3, 32'd1000, 32'd33));
    @(negedge clk);
    n = 0;
    while (MduBusy && n < 100) begin
      chk("stall_held_start", 32'(Stall), 32'd1);
      @(negedge clk);
      n++;
    end
    chk("stall_held_clear", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    MduStart = 1'b0;
    @(negedge clk);
    chk("held_accepted", 32'(MduBusy), 32'd1);
    wait_idle();
    chk("held_lo", LoOut, 32'd30);
    chk("held_hi", HiOut, 32'd10);
    mdl_hi = 32'd10; mdl_lo = 32'd30;

    // MTHI / MTLO / reserved opcodes
    do_op(3'd4, 32'h1234_5678, 32'd0);
    WbSel = 2'd2;
    #1 chk("wb_hi_after_mthi", WbData, 32'h1234_5678);
    WbSel = 2'd0;
    do_op(3'd5, 32'hCAFE_F00D, 32'd0);
    do_op(3'd6, 32'h1111_1111, 32'd0);
    do_op(3'd7, 32'h2222_2222, 32'd0);

    // Reset during a divide aborts it
    do_op(3'd2, 32'h7654_3210, 32'd3);
    repeat (8) @(posedge clk);
    #1;
    abort_pend = 1'b1;
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    chk("abort_busy", 32'(MduBusy), 32'd0);
    chk("abort_hi", HiOut, 32'd0);
    chk("abort_lo", LoOut, 32'd0);
    do_op(3'd0, 32'hFFFF_FF00, 32'h0001_0001);

    // Randomized operations with writeback mux checks
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      wait_idle();
      s = 2'($urandom_range(0, 3));
      x = $urandom;
      AluResult = x;
      MemData = ~x;
      WbSel = s;
      #1;
      chk("rand_wb", WbData, (s == 2'd0) ? x : (s == 2'd1) ? ~x : (s == 2'd2) ? mdl_hi : mdl_lo);
      chk("rand_hi", HiOut, mdl_hi);
      chk("rand_lo", LoOut, mdl_lo);
    end
    WbSel = 2'd0;

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
